// File: rtl/wb_sel_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_sel_stage                                                    |
// | Brief    : Parametrised write-back source select with load extraction,     |
// |            link increment and a stall/flush output register.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wb_sel_stage #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 4,
  parameter int SEL_W   = $clog2(NSRC),
  parameter int MEM_IDX = 3,
  parameter int PC_IDX  = 1,
  parameter int PC_INC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*XLEN-1:0] src,
  input  logic [SEL_W-1:0]     rd_sel,
  input  logic [2:0]           ld_mode,
  input  logic [1:0]           ld_off,
  input  logic                 in_valid,
  input  logic [4:0]           in_rd_addr,
  input  logic                 in_rd_we,
  input  logic                 stall,
  input  logic                 flush,
  output logic [XLEN-1:0]      rd_d,
  output logic [4:0]           rd_addr,
  output logic                 rd_we,
  output logic                 out_valid
);

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  logic [XLEN-1:0] w_src [NSRC];
  logic [XLEN-1:0] w_mem_word;
  logic [XLEN-1:0] w_pc_word;
  logic [XLEN-1:0] w_mem_ext;
  logic [XLEN-1:0] w_sel;
  logic [15:0]     w_half;
  logic [7:0]      w_byte;
  logic [31:0]     w_idx;

  logic [XLEN-1:0] r_d;
  logic [4:0]      r_addr;
  logic            r_we;
  logic            r_valid;

  genvar k;
  generate
    for (k = 0; k < NSRC; k++) begin : g_unpack
      assign w_src[k] = src[k*XLEN +: XLEN];
    end

    // Special indices outside the source range simply never match.
    if (MEM_IDX < NSRC) begin : g_mem
      assign w_mem_word = w_src[MEM_IDX];
    end else begin : g_no_mem
      assign w_mem_word = '0;
    end

    if (PC_IDX < NSRC) begin : g_pc
      assign w_pc_word = w_src[PC_IDX];
    end else begin : g_no_pc
      assign w_pc_word = '0;
    end
  endgenerate

  assign w_half = 16'(w_mem_word >> {ld_off, 3'b000});
  assign w_byte = w_half[7:0];
  assign w_idx  = 32'(rd_sel);

  always_comb begin
    w_mem_ext = w_mem_word;
    case (ld_mode)
      c_LB:    w_mem_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_LBU:   w_mem_ext = {{(XLEN-8){1'b0}}, w_byte};
      c_LH:    w_mem_ext = {{(XLEN-16){w_half[15]}}, w_half};
      c_LHU:   w_mem_ext = {{(XLEN-16){1'b0}}, w_half};
      c_LW:    w_mem_ext = w_mem_word;
      default: w_mem_ext = w_mem_word;
    endcase
  end

  // Later assignments override earlier ones, giving MEM priority over PC.
  always_comb begin
    w_sel = '0;
    if (w_idx < 32'(NSRC)) begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_idx == 32'(i)) w_sel = w_src[i];
      end
      if (w_idx == 32'(PC_IDX))  w_sel = w_pc_word + XLEN'(PC_INC);
      if (w_idx == 32'(MEM_IDX)) w_sel = w_mem_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d     <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_d     <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_addr  <= in_rd_addr;
      r_we    <= in_valid & in_rd_we & (|in_rd_addr);
      if (in_valid) r_d <= w_sel;
    end
  end

  assign rd_d      = r_d;
  assign rd_addr   = r_addr;
  assign rd_we     = r_we;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_wb_sel_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_sel_stage                                                 |
// | Brief    : Self-checking bench for wb_sel_stage: vector table, corner      |
// |            sequences and randomized traffic against a behavioural model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_wb_sel_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] src = '0;
  logic [1:0]   rd_sel = '0;
  logic [2:0]   ld_mode = '0;
  logic [1:0]   ld_off = '0;
  logic         in_valid = 1'b0;
  logic [4:0]   in_rd_addr = '0;
  logic         in_rd_we = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  rd_d;
  logic [4:0]   rd_addr;
  logic         rd_we;
  logic         out_valid;

  // Second instance: three sources, so rd_sel=3 is out of range.
  logic [95:0]  b_src = '0;
  logic [1:0]   b_sel = '0;
  logic         b_one = 1'b1;
  logic         b_zero = 1'b0;
  logic [4:0]   b_addr_in = 5'd7;
  logic [31:0]  b_rd_d;
  logic [4:0]   b_rd_addr;
  logic         b_rd_we;
  logic         b_out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_d;
  logic [4:0]  m_addr;
  logic        m_we;
  logic        m_valid;

  wb_sel_stage dut (
    .clk(clk), .rst(rst), .src(src), .rd_sel(rd_sel), .ld_mode(ld_mode),
    .ld_off(ld_off), .in_valid(in_valid), .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .stall(stall), .flush(flush), .rd_d(rd_d),
    .rd_addr(rd_addr), .rd_we(rd_we), .out_valid(out_valid)
  );

  wb_sel_stage #(.NSRC(3), .MEM_IDX(2), .PC_IDX(1)) dut3 (
    .clk(clk), .rst(rst), .src(b_src), .rd_sel(b_sel), .ld_mode(ld_mode),
    .ld_off(ld_off), .in_valid(b_one), .in_rd_addr(b_addr_in),
    .in_rd_we(b_one), .stall(b_zero), .flush(b_zero), .rd_d(b_rd_d),
    .rd_addr(b_rd_addr), .rd_we(b_rd_we), .out_valid(b_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          mode;
    int          off;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  // Reference select computed from the load/link rules with plain arithmetic.
  function automatic logic [31:0] ref_sel(input logic [127:0] s, input int sel,
                                          input int mode, input int off);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = s[sel*32 +: 32];
    b = (w >> (8 * off)) % 256;
    h = (w >> (8 * off)) % 65536;
    if (sel == 1) return w + 32'd4;
    if (sel != 3) return w;
    case (mode)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_d = '0; m_addr = '0; m_we = 1'b0; m_valid = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic cyc(input string nm);
    if (flush) begin
      model_reset();
    end else if (!stall) begin
      m_valid = in_valid;
      m_addr  = in_rd_addr;
      m_we    = in_valid && in_rd_we && (in_rd_addr != 5'd0);
      if (in_valid) m_d = ref_sel(src, int'(rd_sel), int'(ld_mode), int'(ld_off));
    end
    @(posedge clk);
    #1;
    chk({nm, ".d"}, rd_d, m_d);
    chk({nm, ".addr"}, {27'd0, rd_addr}, {27'd0, m_addr});
    chk({nm, ".we"}, {31'd0, rd_we}, {31'd0, m_we});
    chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".d"}, rd_d, 32'd0);
    chk({nm, ".addr"}, {27'd0, rd_addr}, 32'd0);
    chk({nm, ".we"}, {31'd0, rd_we}, 32'd0);
    chk({nm, ".valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t tbl[13];
  logic [31:0] hold_d;

  initial begin
    model_reset();
    tbl[0]  = '{0, 2, 0, 32'h1000_0000, 32'h0000_0100, 32'hFFFF_FFFC};
    tbl[1]  = '{1, 2, 0, 32'h1000_0000, 32'h0000_0100, 32'h0000_0104};
    tbl[2]  = '{2, 2, 0, 32'h1000_0000, 32'h0000_0100, 32'hDEAD_BEEF};
    tbl[3]  = '{3, 2, 0, 32'h1000_0000, 32'h0000_0100, 32'h1000_0000};
    tbl[4]  = '{3, 0, 0, 32'h80F0_7F81, 32'h0000_0100, 32'hFFFF_FF81};
    tbl[5]  = '{3, 4, 0, 32'h80F0_7F81, 32'h0000_0100, 32'h0000_0081};
    tbl[6]  = '{3, 0, 1, 32'h80F0_7F81, 32'h0000_0100, 32'h0000_007F};
    tbl[7]  = '{3, 1, 2, 32'h80F0_7F81, 32'h0000_0100, 32'hFFFF_80F0};
    tbl[8]  = '{3, 5, 2, 32'h80F0_7F81, 32'h0000_0100, 32'h0000_80F0};
    tbl[9]  = '{3, 1, 3, 32'h80F0_7F81, 32'h0000_0100, 32'h0000_0080};
    tbl[10] = '{3, 2, 2, 32'h80F0_7F81, 32'h0000_0100, 32'h80F0_7F81};
    tbl[11] = '{3, 3, 1, 32'h80F0_7F81, 32'h0000_0100, 32'h80F0_7F81};
    tbl[12] = '{1, 2, 0, 32'h1000_0000, 32'hFFFF_FFFE, 32'h0000_0002};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Three-source instance: in-range then out-of-range select.
    b_src = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    b_sel = 2'd0;
    cyc("idle");
    chk("n3.sel0", b_rd_d, 32'h1111_1111);
    b_sel = 2'd3;
    cyc("idle2");
    chk("n3.oor", b_rd_d, 32'h0000_0000);
    chk("n3.valid", {31'd0, b_out_valid}, 32'd1);

    // Source sweep and load extraction table.
    in_valid = 1'b1; in_rd_we = 1'b1; in_rd_addr = 5'd5;
    for (int i = 0; i < 13; i++) begin
      src     = {tbl[i].mem, 32'hDEAD_BEEF, tbl[i].pc, 32'hFFFF_FFFC};
      rd_sel  = 2'(tbl[i].sel);
      ld_mode = 3'(tbl[i].mode);
      ld_off  = 2'(tbl[i].off);
      cyc("tbl");
      chk($sformatf("tbl%0d", i), rd_d, tbl[i].exp);
    end

    // Writes to x0 are suppressed but still valid.
    in_rd_addr = 5'd0;
    cyc("x0");
    chk("x0.we", {31'd0, rd_we}, 32'd0);
    chk("x0.valid", {31'd0, out_valid}, 32'd1);

    // Stall holds outputs while inputs change.
    in_rd_addr = 5'd9; rd_sel = 2'd2;
    cyc("prestall");
    hold_d = rd_d;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src = {$urandom, $urandom, $urandom, $urandom};
      rd_sel = 2'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom_range(1, 31));
      cyc("stall");
      chk("stall.hold", rd_d, hold_d);
    end

    // Flush wins over stall.
    flush = 1'b1;
    cyc("stflush");
    chk_zero("stflush");
    stall = 1'b0; flush = 1'b0;

    // Invalid input: valid drops, data holds.
    src = {32'h0, 32'h0, 32'h0, 32'h1234_5678}; rd_sel = 2'd0; in_rd_addr = 5'd3;
    cyc("prevalid");
    in_valid = 1'b0; src = '0;
    cyc("invalid");
    chk("invalid.d", rd_d, 32'h1234_5678);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    cyc("prerst");
    rst = 1'b1;
    #2;
    chk_zero("asyncrst");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("rsthold");
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      src        = {$urandom, $urandom, $urandom, $urandom};
      rd_sel     = 2'($urandom_range(0, 3));
      ld_mode    = 3'($urandom_range(0, 7));
      ld_off     = 2'($urandom_range(0, 3));
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rd_we   = ($urandom_range(0, 3) != 0);
      in_rd_addr = 5'($urandom_range(0, 31));
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_sel_stage.md
Name: wb_sel_stage

Overview:
- Parametrised write-back select stage; successor to the fixed 4-input rd_mux.
- Selects one of NSRC XLEN-bit result sources (imm, pc, alu_out, rd_mem, ...) for the register-file write port.
- Applies load byte/half extraction and sign/zero extension on the memory source, and pc+PC_INC on the link source.
- Registers the result with destination address and write enable; supports stall and flush. Sits between MEM/EX outputs and the register file.

Parameters:
- XLEN, 32, data width; legal values are 16 or more.
- NSRC, 4, number of sources; legal values are 2 or more.
- SEL_W, $clog2(NSRC), rd_sel width; derived, do not override.
- MEM_IDX, 3, source index that receives load extraction.
- PC_IDX, 1, source index that receives +PC_INC.
- PC_INC, 4, link increment added to the PC source.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- src  in  NSRC*XLEN  packed sources; source k occupies [k*XLEN +: XLEN]
- rd_sel  in  SEL_W  source select
- ld_mode  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_off  in  2  byte offset of the load address
- in_valid  in  1  input instruction valid
- in_rd_addr  in  5  destination register
- in_rd_we  in  1  instruction writes rd
- stall  in  1  hold the output register
- flush  in  1  kill the output register
- rd_d  out  XLEN  registered write data
- rd_addr  out  5  registered destination
- rd_we  out  1  registered write enable
- out_valid  out  1  registered valid

Behaviour:
- Reset (asynchronous, rst=1): rd_d=0, rd_addr=0, rd_we=0, out_valid=0, effective immediately and held while rst=1.
- Combinational select value `sel`:
  - rd_sel >= NSRC: sel = 0.
  - rd_sel == PC_IDX: sel = src[PC_IDX] + PC_INC, mod 2^XLEN (wraps).
  - rd_sel == MEM_IDX: let w = src[MEM_IDX] and sh = w >> (8*ld_off), logical with zero fill.
    - LB: sign-extend sh[7:0].
    - LBU: zero-extend sh[7:0].
    - LH: sign-extend sh[15:0].
    - LHU: zero-extend sh[15:0].
    - LW: w unshifted; ld_off is ignored.
    - Any other ld_mode: w unshifted.
    - A misaligned half (ld_off=3) therefore yields {0, byte3} before extension; the result is deterministic and no trap is raised.
  - Otherwise: sel = src[rd_sel].
  - If MEM_IDX == PC_IDX, MEM_IDX takes priority.
- Register update at posedge clk, highest priority first:
  1. flush=1: out_valid<=0, rd_we<=0, rd_d<=0, rd_addr<=0. This applies even when stall=1.
  2. stall=1: all outputs hold.
  3. Otherwise:
     - out_valid<=in_valid.
     - rd_addr<=in_rd_addr.
     - rd_we<=in_valid & in_rd_we & (in_rd_addr!=0); x0 is never written.
     - rd_d<=sel if in_valid, else rd_d holds.
- Latency: exactly 1 cycle from input to outputs; throughput 1 per cycle when not stalled.
- Reset mid-stall or mid-flush: reset wins asynchronously. The first edge after rst deasserts follows the normal priority.
- Inputs are sampled only at clock edges; outputs never change combinationally with inputs.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> all outputs 0. Assert rst mid-stream with out_valid=1 -> outputs become 0 before the next edge.
- Source sweep (NSRC=4): src = {0x1000_0000 (mem), 0xDEAD_BEEF (alu), 0x0000_0100 (pc), 0xFFFF_FFFC (imm)}, in_valid=1, in_rd_we=1, rd_addr=5.
  - rd_sel=0 -> rd_d=0xFFFF_FFFC.
  - rd_sel=1 -> 0x0000_0104.
  - rd_sel=2 -> 0xDEAD_BEEF.
  - Each appears one cycle later with rd_we=1.
- Loads on mem=0x80F0_7F81:
  - LB off0 -> 0xFFFF_FF81.
  - LBU off0 -> 0x0000_0081.
  - LB off1 -> 0x0000_007F.
  - LH off2 -> 0xFFFF_80F0.
  - LHU off2 -> 0x0000_80F0.
  - LH off3 -> 0x0000_0080.
  - LW off2 -> 0x80F0_7F81.
- PC wrap: pc=0xFFFF_FFFE, rd_sel=1 -> rd_d=0x0000_0002.
- x0 and out-of-range: in_rd_addr=0, in_rd_we=1 -> rd_we=0 and out_valid=1. With NSRC=3 and rd_sel=3 -> rd_d=0.
- Stall/flush:
  - stall for 3 cycles while the inputs change -> outputs hold the pre-stall values.
  - stall=1 and flush=1 together -> out_valid=0, rd_we=0, rd_d=0.
  - in_valid=0 -> out_valid=0 and rd_d holds.
